button_events: RTL and testbench
================================

# button_events

Classifies the debounced button level produced by the `debounce` stage into single-cycle event strobes: press, release (short or long), long-press and auto-repeat. It sits directly downstream of `debounce` and feeds the UI/menu logic, which consumes strobes only and never samples raw levels. All outputs are registered, and each strobe is high for exactly one `clk` cycle.

## Interface
Parameters:
- `CNT_W`, 24: hold-counter width.
- `LONG_CYCLES`, 12000000: cycles from the `press` strobe to the `long_press` strobe. Legal range 2..2^CNT_W-1.
- `REPEAT_CYCLES`, 3000000: cycles between `long_press` and the first `repeat`, and between consecutive `repeat` strobes. 0 disables repeat. Otherwise legal range 2..2^CNT_W-1.

Ports:
- `clk`, input, 1: the single clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `in`, input, 1: debounced button level from `debounce` (1 = pressed), synchronous to `clk`.
- `held`, output, 1: level; 1 while the FSM is in PRESSED or LONG.
- `press`, output, 1: strobe on the rising edge of `in`.
- `release_short`, output, 1: strobe on release before `long_press` fired.
- `release_long`, output, 1: strobe on release after `long_press` fired.
- `long_press`, output, 1: strobe after the button is held `LONG_CYCLES` cycles.
- `repeat`, output, 1: strobe every `REPEAT_CYCLES` cycles while in LONG.

## Operation
- `in_q` is a one-cycle registered copy of `in`. A rise is `in` & ~`in_q`. A fall is ~`in` while the FSM is in PRESSED or LONG.
- `cnt` is `CNT_W` bits wide. It is reset to 0 on every state entry and never wraps: the compare fires before overflow.
- FSM states:
  - IDLE: on a rise, go to PRESSED, set `cnt` <= 0, and strobe `press`. Otherwise stay.
  - PRESSED:
    - If `in` = 0: go to IDLE and strobe `release_short`.
    - Else if `cnt` == `LONG_CYCLES`-1: go to LONG, set `cnt` <= 0, and strobe `long_press`.
    - Else `cnt` <= `cnt`+1.
  - LONG:
    - If `in` = 0: go to IDLE and strobe `release_long`.
    - Else if `REPEAT_CYCLES` != 0 and `cnt` == `REPEAT_CYCLES`-1: strobe `repeat` and set `cnt` <= 0.
    - Else `cnt` <= `cnt`+1. When `REPEAT_CYCLES` = 0, `cnt` holds instead of incrementing.
- Priority: release beats long/repeat. If `in` is sampled low on the edge where a threshold would match, only the release strobe is emitted.
- At most one strobe is high in any cycle.
- `held` = (next state != IDLE), registered, so it rises with `press` and falls with the release strobe.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `in_q` = 1.
  - All strobes = 0, `held` = 0.
- Because `in_q` resets to 1, a button held through reset produces no `press`. The first `press` requires `in` to be sampled 0, then 1, after reset.
- Reset mid-press (PRESSED or LONG): outputs go to 0 on the reset edge, and no release strobe is emitted.
- Latency:
  - `press` is high the cycle after the first edge at which `in` = 1 and `in_q` = 0.
  - A release strobe is high the cycle after the first edge at which `in` = 0.
- Strobe positions: if `press` is in cycle P, then `long_press` is in cycle P+`LONG_CYCLES` and `repeat` is in cycles P+`LONG_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1, while `in` stays 1.
- Minimum press: `in` high for 1 cycle gives `press` in cycle P and `release_short` in cycle P+1.
- Back-to-back presses: a rise on the edge immediately after the release edge is legal and yields `press` with no gap cycle required.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=4.
- Reset with `in`=1 held, then 20 cycles: no strobes and `held`=0. Drop `in` for 1 cycle and raise it again: `press` fires 1 cycle after the rise.
- Short press, `in` high for 5 cycles: `press` at P and `release_short` at P+5. `held` is high for cycles P..P+4. No `long_press`.
- Hold for 20 cycles: `press` at P, `long_press` at P+8, `repeat` at P+12 and P+16. `release_long` fires 1 cycle after `in` falls.
- Boundary, release exactly when the long threshold would match (`in` high for 8 cycles): `release_short` at P+8 and no `long_press`. Repeat the check with `in` high for 9 cycles: `long_press` at P+8, then `release_long` at P+9.
- `REPEAT_CYCLES`=0 variant, hold for 40 cycles: a single `long_press` at P+8 and no `repeat`.
- Reset asserted at P+10 during LONG: all outputs 0 on the next cycle and no release strobe. Behaviour after reset matches the first scenario.

Source files
------------

// File: rtl/button_events.sv
// Turns the debounced button level into one-cycle press / release / long-press / repeat strobes.
// All outputs are registered, and at most one strobe is high in any cycle.
module button_events #(
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 3000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_held,
  output logic o_press,
  output logic o_release_short,
  output logic o_release_long,
  output logic o_long_press,
  output logic o_repeat
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic             C_REP_EN    = (REPEAT_CYCLES != 0);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_q;
  logic               r_held;
  logic               r_press;
  logic               r_release_short;
  logic               r_release_long;
  logic               r_long_press;
  logic               r_repeat;

  state_t             w_state_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_rise;
  logic               w_held_nx;
  logic               w_press_nx;
  logic               w_release_short_nx;
  logic               w_release_long_nx;
  logic               w_long_press_nx;
  logic               w_repeat_nx;

  // Next-state, hold counter and strobe decode; release always wins over a threshold match.
  always_comb begin
    w_rise             = i_in & ~r_in_q;
    w_state_nx         = r_state;
    w_cnt_nx           = r_cnt;
    w_press_nx         = 1'b0;
    w_release_short_nx = 1'b0;
    w_release_long_nx  = 1'b0;
    w_long_press_nx    = 1'b0;
    w_repeat_nx        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nx = S_PRESSED;
          w_cnt_nx   = {CNT_W{1'b0}};
          w_press_nx = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = {CNT_W{1'b0}};
        end
      end
      S_PRESSED: begin
        if (!i_in) begin
          w_state_nx         = S_IDLE;
          w_cnt_nx           = {CNT_W{1'b0}};
          w_release_short_nx = 1'b1;
        end else if (r_cnt == C_LONG_LAST) begin
          w_state_nx      = S_LONG;
          w_cnt_nx        = {CNT_W{1'b0}};
          w_long_press_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end
      end
      S_LONG: begin
        if (!i_in) begin
          w_state_nx        = S_IDLE;
          w_cnt_nx          = {CNT_W{1'b0}};
          w_release_long_nx = 1'b1;
        end else if (C_REP_EN && (r_cnt == C_REP_LAST)) begin
          w_cnt_nx    = {CNT_W{1'b0}};
          w_repeat_nx = 1'b1;
        end else if (C_REP_EN) begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end else begin
          // With repeat disabled the counter parks so it can never overflow.
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = {CNT_W{1'b0}};
      end
    endcase

    w_held_nx = (w_state_nx != S_IDLE);
  end

  // State, counter, input history and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= {CNT_W{1'b0}};
      r_in_q          <= 1'b1;
      r_held          <= 1'b0;
      r_press         <= 1'b0;
      r_release_short <= 1'b0;
      r_release_long  <= 1'b0;
      r_long_press    <= 1'b0;
      r_repeat        <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_cnt           <= w_cnt_nx;
      r_in_q          <= i_in;
      r_held          <= w_held_nx;
      r_press         <= w_press_nx;
      r_release_short <= w_release_short_nx;
      r_release_long  <= w_release_long_nx;
      r_long_press    <= w_long_press_nx;
      r_repeat        <= w_repeat_nx;
    end
  end

  assign o_held          = r_held;
  assign o_press         = r_press;
  assign o_release_short = r_release_short;
  assign o_release_long  = r_release_long;
  assign o_long_press    = r_long_press;
  assign o_repeat        = r_repeat;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with LONG_CYCLES=8, REPEAT_CYCLES=4 (dut_a) and REPEAT_CYCLES=0 (dut_b).
// Outputs are packed as {held, press, release_short, release_long, long_press, repeat}.
module tb_button_events;

  logic clk;
  logic rst;
  logic in_a;
  logic in_b;
  logic use_b;

  logic a_held, a_press, a_rs, a_rl, a_lp, a_rep;
  logic b_held, b_press, b_rs, b_rl, b_lp, b_rep;

  int n_tests;
  int n_fail;

  button_events #(.CNT_W(8), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_in(in_a),
    .o_held(a_held), .o_press(a_press), .o_release_short(a_rs),
    .o_release_long(a_rl), .o_long_press(a_lp), .o_repeat(a_rep)
  );

  button_events #(.CNT_W(8), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_in(in_b),
    .o_held(b_held), .o_press(b_press), .o_release_short(b_rs),
    .o_release_long(b_rl), .o_long_press(b_lp), .o_repeat(b_rep)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    if (use_b) return {b_held, b_press, b_rs, b_rl, b_lp, b_rep};
    else       return {a_held, a_press, a_rs, a_rl, a_lp, a_rep};
  endfunction

  // Expected outputs at cycle P+t for a press lasting h sampled-high cycles (L=8, R=4).
  function automatic logic [5:0] exp_at(input int t, input int h, input bit rep_en);
    logic [5:0] e;
    e = 6'b000000;
    if (t == 0) begin
      e = 6'b110000;
    end else if (t < h) begin
      e[5] = 1'b1;
      if (t == 8) e[1] = 1'b1;
      if (rep_en && (t > 8) && (((t - 8) % 4) == 0)) e[0] = 1'b1;
    end else if (t == h) begin
      if (h > 8) e[2] = 1'b1;
      else       e[3] = 1'b1;
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (held,press,rs,rl,lp,rep) at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    if (use_b) in_b = v;
    else       in_a = v;
  endtask

  // Raise the input, keep it sampled high for h edges, then watch through the release.
  task automatic run_press(input string tag, input int h, input bit rep_en);
    drive(1'b1);
    for (int t = 0; t <= h + 2; t++) begin
      tick();
      check_eq($sformatf("%s_t%0d", tag, t), obs(), exp_at(t, h, rep_en));
      drive(((t + 1) < h) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    in_a    = 1'b1;
    in_b    = 1'b0;
    use_b   = 1'b0;
    n_tests = 0;
    n_fail  = 0;

    // Button held through reset: no press until a 0 is seen.
    repeat (3) tick();
    check_eq("reset_outs", obs(), 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq($sformatf("held_thru_rst_%0d", i), obs(), 6'b000000);
    end
    drive(1'b0);
    tick();
    check_eq("drop_one", obs(), 6'b000000);
    run_press("first", 3, 1'b1);

    run_press("short5", 5, 1'b1);
    run_press("hold20", 20, 1'b1);
    run_press("edge8", 8, 1'b1);
    run_press("edge9", 9, 1'b1);
    run_press("min1", 1, 1'b1);

    // Back-to-back: rise on the edge right after the release edge.
    drive(1'b1);
    tick();
    check_eq("b2b_press0", obs(), 6'b110000);
    drive(1'b0);
    tick();
    check_eq("b2b_rel0", obs(), 6'b001000);
    drive(1'b1);
    tick();
    check_eq("b2b_press1", obs(), 6'b110000);
    drive(1'b0);
    tick();
    check_eq("b2b_rel1", obs(), 6'b001000);
    tick();
    check_eq("b2b_quiet", obs(), 6'b000000);

    use_b = 1'b1;
    run_press("norep40", 40, 1'b0);
    use_b = 1'b0;

    // Reset during LONG at P+10: outputs clear, no release strobe.
    drive(1'b1);
    for (int t = 0; t <= 10; t++) begin
      tick();
      check_eq($sformatf("long_pre_rst_t%0d", t), obs(), exp_at(t, 1000, 1'b1));
    end
    rst = 1'b1;
    tick();
    check_eq("rst_in_long", obs(), 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq($sformatf("post_rst_held_%0d", i), obs(), 6'b000000);
    end
    drive(1'b0);
    tick();
    check_eq("post_rst_drop", obs(), 6'b000000);
    run_press("after_rst", 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
